pdm_fir_decimator: RTL
======================

Name: pdm_fir_decimator

Overview:
- Time-multiplexed symmetric FIR decimation filter for the PDM-to-PCM converter. Sits directly downstream of the CIC stage.
- Accepts CIC output samples over a valid/ready handshake and stores them in a NUM_TAPS-deep circular buffer.
- Every DECIM_FACTOR accepted samples, runs one pre-add/multiply/accumulate pass using coefficients from the fir_coefficients package (get_coefficient).
- Emits one rounded PCM sample over a valid/ready handshake.

Parameters:
- DATA_WIDTH, 24, signed input sample width
- COEFF_WIDTH, 16, unsigned coefficient width (Q0.16, from get_coefficient)
- NUM_TAPS, 64, filter length; must be even; NUM_TAPS/2 MAC cycles per output
- DECIM_FACTOR, 2, input samples consumed per output sample
- OUT_WIDTH, 24, signed output sample width

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- in_data_i  in  DATA_WIDTH  signed sample from CIC
- in_valid_i  in  1  input sample valid
- in_ready_o  out  1  decimator can accept a sample
- out_data_o  out  OUT_WIDTH  signed PCM sample
- out_valid_o  out  1  output sample valid
- out_ready_i  in  1  downstream accepts the output
- sat_o  out  1  pulses with an output that was saturated (see Optional Feature)

Interface: one clock, clk_i. Reset rst_i is synchronous and active-high.

Behaviour:
- Reset:
  - FSM goes to COLLECT.
  - All buffer entries, write pointer, sample counter and accumulator are cleared to 0.
  - in_ready_o=1, out_valid_o=0, out_data_o=0, sat_o=0.
  - Reset takes priority in any state, including mid-COMPUTE or while OUTPUT is held. The partial result is discarded.
- States: COLLECT, COMPUTE, ROUND, OUTPUT.
- COLLECT:
  - in_ready_o=1.
  - A sample is accepted when in_valid_i and in_ready_o are both high. It is written at the write pointer; the pointer increments modulo NUM_TAPS. The sample counter increments.
  - When the counter reaches DECIM_FACTOR on an accept, the counter clears and the FSM goes to COMPUTE on the next cycle.
- COMPUTE:
  - in_ready_o=0. Runs exactly NUM_TAPS/2 cycles, k = 0..NUM_TAPS/2-1.
  - x[0] is the newest sample; x[j] is the sample j accepts ago. Buffer slots not yet written read as 0.
  - Each cycle: acc += (x[k] + x[NUM_TAPS-1-k]) * c[k].
  - The pre-add is DATA_WIDTH+1 bits signed. c[k] is zero-extended to COEFF_WIDTH+1 bits signed.
  - ACC_WIDTH = DATA_WIDTH+COEFF_WIDTH+2+clog2(NUM_TAPS/2). The accumulator is never truncated.
  - acc is cleared at COMPUTE entry.
- ROUND (1 cycle):
  - y = (acc + 2^(COEFF_WIDTH-1)) >>> COEFF_WIDTH, round-half-up arithmetic.
  - y is fitted to OUT_WIDTH (see Optional Feature) and registered into out_data_o.
  - out_valid_o is set on the next cycle.
- OUTPUT:
  - out_valid_o=1; out_data_o and sat_o are held stable until out_ready_i=1.
  - On the handshake cycle: out_valid_o clears next cycle, sat_o clears, FSM goes to COLLECT.
  - in_ready_o=0 throughout OUTPUT. No input is accepted while a result is pending, so no sample is dropped.
- Latency: from the accept cycle of the DECIM_FACTOR-th sample to out_valid_o high is NUM_TAPS/2+2 cycles (34 at defaults).
- Throughput:
  - Minimum cycles per output = DECIM_FACTOR + NUM_TAPS/2 + 2.
  - Upstream must tolerate in_ready_o low. The CIC output rate is far below this bound at the defaults.
- Wrap-around: the pointer wraps 63→0 with no gap. Tap addressing is (wr_ptr-1-j) mod NUM_TAPS.
- Simultaneous events: out_ready_i while out_valid_o=0 is ignored. in_valid_i outside COLLECT is ignored and the data is not stored.

Optional Feature:
- Macro PDM_PCM_FIR_SAT_EN.
- Defined:
  - y above 2^(OUT_WIDTH-1)-1 clamps to the maximum; y below -2^(OUT_WIDTH-1) clamps to the minimum.
  - sat_o=1 alongside that output for the duration of its out_valid_o.
- Undefined:
  - y is truncated to its low OUT_WIDTH bits (two's-complement wrap).
  - sat_o is tied 0.

Test Plan:
- Reset check: assert rst_i for 3 cycles mid-stream -> next cycle out_valid_o=0, out_data_o=0, in_ready_o=1. Then feed 64 zeros -> 32 outputs, all 0.
- Impulse response: feed 65536, then 127 zeros -> outputs out[m] = get_coefficient(2m+1) for m=0..31, then 0. First out_valid_o exactly 34 cycles after the 2nd accept.
- Backpressure: hold out_ready_i=0 for 20 cycles while feeding in_valid_i=1 -> out_data_o stable, in_ready_o=0. After release, the sample sequence is unchanged versus a no-stall run.
- Saturation (macro defined): constant input 8388607 for 128 samples -> out_data_o=8388607, sat_o=1. Constant -8388608 -> -8388608, sat_o=1.
- Wrap without macro: same constant 8388607 input -> out_data_o equals the low 24 bits of the golden-model y, sat_o=0.
- Pointer wrap and random data: 1000 random signed 24-bit samples with random in_valid_i/out_ready_i gaps -> bit-exact match to the reference model across multiple 63→0 pointer wraps.

Source files
------------

// File: rtl/pdm_fir_decimator.sv
`default_nettype none
// ============================================================================
// Module      : pdm_fir_decimator  (with package fir_coefficients)
// Description : Time-multiplexed symmetric FIR decimation filter placed after
//               the CIC stage of the PDM-to-PCM converter. CIC samples enter a
//               NUM_TAPS-deep circular buffer; every DECIM_FACTOR accepted
//               samples one pre-add/multiply/accumulate pass of NUM_TAPS/2
//               cycles runs, the result is rounded half-up and presented on a
//               valid/ready output.
// Ports       : clk_i        clock
//               rst_i        synchronous active-high reset
//               in_data_i    signed CIC sample (DATA_WIDTH)
//               in_valid_i   input sample valid
//               in_ready_o   decimator can accept a sample (COLLECT only)
//               out_data_o   signed PCM sample (OUT_WIDTH)
//               out_valid_o  output sample valid
//               out_ready_i  downstream accepts the output
//               sat_o        output currently presented was saturated
// Options     : PDM_PCM_FIR_SAT_EN defined   -> clamp to OUT_WIDTH, sat_o live
//               PDM_PCM_FIR_SAT_EN undefined -> two's-complement wrap, sat_o=0
// Notes       : NUM_TAPS must be an even power of two (pointer wraps for free).
// Revision    : 1.0 - initial release
// ============================================================================

package fir_coefficients;
    // Symmetric 64-tap triangular low-pass, Q0.16. Index mirrors about 31.5.
    function automatic logic [15:0] get_coefficient(input int idx);
        int m;
        m = (idx < 32) ? idx : 63 - idx;
        return 16'((m + 1) * 64);
    endfunction
endpackage

module pdm_fir_decimator #(
    parameter int DATA_WIDTH   = 24,
    parameter int COEFF_WIDTH  = 16,
    parameter int NUM_TAPS     = 64,
    parameter int DECIM_FACTOR = 2,
    parameter int OUT_WIDTH    = 24
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic signed [DATA_WIDTH-1:0] in_data_i,
    input  logic                         in_valid_i,
    output logic                         in_ready_o,
    output logic signed [OUT_WIDTH-1:0]  out_data_o,
    output logic                         out_valid_o,
    input  logic                         out_ready_i,
    output logic                         sat_o
);

    localparam int c_PTR_W  = $clog2(NUM_TAPS);
    localparam int c_HALF   = NUM_TAPS / 2;
    localparam int c_PROD_W = DATA_WIDTH + COEFF_WIDTH + 2;
    localparam int c_ACC_W  = c_PROD_W + $clog2(c_HALF);
    localparam int c_CNT_W  = $clog2(DECIM_FACTOR + 1);

    localparam logic [c_CNT_W-1:0]        c_CNT_LAST = c_CNT_W'(DECIM_FACTOR - 1);
    localparam logic [c_PTR_W-1:0]        c_K_LAST   = c_PTR_W'(c_HALF - 1);
    localparam logic signed [c_ACC_W-1:0] c_RND      = c_ACC_W'(1) <<< (COEFF_WIDTH - 1);

    typedef enum logic [1:0] {
        S_COLLECT = 2'd0,
        S_COMPUTE = 2'd1,
        S_ROUND   = 2'd2,
        S_OUTPUT  = 2'd3
    } state_t;

    state_t r_state, w_next;

    logic signed [DATA_WIDTH-1:0] r_buf [NUM_TAPS];
    logic [c_PTR_W-1:0]           r_wr_ptr, r_k, w_idx_a, w_idx_b;
    logic [c_CNT_W-1:0]           r_cnt;
    logic signed [c_ACC_W-1:0]    r_acc, w_prod_ext, w_rnd, w_y;
    logic signed [DATA_WIDTH-1:0] w_xa, w_xb;
    logic signed [DATA_WIDTH:0]   w_pre;
    logic [COEFF_WIDTH-1:0]       w_coef;
    logic signed [c_PROD_W-1:0]   w_pre_ext, w_coef_ext, w_prod;
    logic signed [OUT_WIDTH-1:0]  r_out_data, w_fit;
    logic                         r_out_valid, w_in_ready, w_accept, w_last;

    // x[k] lives at (wr_ptr-1-k); x[NUM_TAPS-1-k] folds to (wr_ptr+k) mod NUM_TAPS.
    assign w_idx_a = r_wr_ptr - c_PTR_W'(1) - r_k;
    assign w_idx_b = r_wr_ptr + r_k;
    assign w_xa    = r_buf[w_idx_a];
    assign w_xb    = r_buf[w_idx_b];
    assign w_pre   = {w_xa[DATA_WIDTH-1], w_xa} + {w_xb[DATA_WIDTH-1], w_xb};
    assign w_coef  = COEFF_WIDTH'(fir_coefficients::get_coefficient(int'(r_k)));

    // Operands widened to the full product width so the signed multiply is exact.
    assign w_pre_ext  = {{(c_PROD_W-DATA_WIDTH-1){w_pre[DATA_WIDTH]}}, w_pre};
    assign w_coef_ext = {{(c_PROD_W-COEFF_WIDTH){1'b0}}, w_coef};
    assign w_prod     = w_pre_ext * w_coef_ext;
    assign w_prod_ext = {{(c_ACC_W-c_PROD_W){w_prod[c_PROD_W-1]}}, w_prod};

    assign w_rnd = r_acc + c_RND;
    assign w_y   = w_rnd >>> COEFF_WIDTH;

`ifdef PDM_PCM_FIR_SAT_EN
    localparam logic signed [c_ACC_W-1:0] c_OUT_MAX =
        {{(c_ACC_W-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [c_ACC_W-1:0] c_OUT_MIN =
        {{(c_ACC_W-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

    logic w_sat;
    logic r_sat;

    always_comb begin
        w_sat = 1'b0;
        w_fit = w_y[OUT_WIDTH-1:0];
        if (w_y > c_OUT_MAX) begin
            w_fit = {1'b0, {(OUT_WIDTH-1){1'b1}}};
            w_sat = 1'b1;
        end else if (w_y < c_OUT_MIN) begin
            w_fit = {1'b1, {(OUT_WIDTH-1){1'b0}}};
            w_sat = 1'b1;
        end
    end

    assign sat_o = r_sat;
`else
    logic w_unused_y;

    assign w_fit      = w_y[OUT_WIDTH-1:0];
    assign w_unused_y = ^w_y[c_ACC_W-1:OUT_WIDTH];
    assign sat_o      = 1'b0;
`endif

    // Next-state and handshake decode
    always_comb begin
        w_next     = r_state;
        w_in_ready = 1'b0;
        w_accept   = 1'b0;
        w_last     = 1'b0;
        case (r_state)
            S_COLLECT: begin
                w_in_ready = 1'b1;
                if (in_valid_i) begin
                    w_accept = 1'b1;
                    if (r_cnt == c_CNT_LAST) begin
                        w_last = 1'b1;
                        w_next = S_COMPUTE;
                    end
                end
            end
            S_COMPUTE: if (r_k == c_K_LAST) w_next = S_ROUND;
            S_ROUND:   w_next = S_OUTPUT;
            S_OUTPUT:  if (r_out_valid && out_ready_i) w_next = S_COLLECT;
            default:   w_next = S_COLLECT;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) r_state <= S_COLLECT;
        else       r_state <= w_next;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_TAPS; i++) r_buf[i] <= '0;
            r_wr_ptr    <= '0;
            r_cnt       <= '0;
            r_k         <= '0;
            r_acc       <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
`ifdef PDM_PCM_FIR_SAT_EN
            r_sat       <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_COLLECT: begin
                    if (w_accept) begin
                        r_buf[r_wr_ptr] <= in_data_i;
                        r_wr_ptr        <= r_wr_ptr + c_PTR_W'(1);
                        if (w_last) begin
                            r_cnt <= '0;
                            r_acc <= '0;
                            r_k   <= '0;
                        end else begin
                            r_cnt <= r_cnt + c_CNT_W'(1);
                        end
                    end
                end
                S_COMPUTE: begin
                    r_acc <= r_acc + w_prod_ext;
                    r_k   <= r_k + c_PTR_W'(1);
                end
                S_ROUND: begin
                    r_out_data  <= w_fit;
                    r_out_valid <= 1'b1;
`ifdef PDM_PCM_FIR_SAT_EN
                    r_sat       <= w_sat;
`endif
                end
                S_OUTPUT: begin
                    if (r_out_valid && out_ready_i) begin
                        r_out_valid <= 1'b0;
`ifdef PDM_PCM_FIR_SAT_EN
                        r_sat       <= 1'b0;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready_o  = w_in_ready;
    assign out_data_o  = r_out_data;
    assign out_valid_o = r_out_valid;

endmodule
`default_nettype wire
